bht_access_scheduler: RTL

- Owns the single port of the branch history table (BHT) array of 2-bit saturating counters.
- Sequences a power-up init sweep.
- Arbitrates per cycle between fetch-stage prediction lookups and execute-stage resolution updates.
- Buffers updates in a small FIFO and performs each update as a 2-cycle read-modify-write; anti-starvation guarantees updates drain under continuous fetch.

---
 rtl/bht_sched_if.sv | 49 ++++
 rtl/bht_access_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bht_sched_if.sv
// -----------------------------------------------------------------------------
// bht_sched_if
// Groups the signals of the BHT access scheduler: the fetch lookup handshake,
// the execute update handshake, the init status flag and the single-port
// array interface.
//
// Modports:
//   slave  - the scheduler (bht_access_scheduler).
//   master - everything around it: fetch, execute and the BHT array.
//
// Signals:
//   lookup_valid/lookup_addr/lookup_ready  fetch prediction request
//   pred_valid/pred_taken                  prediction, 1 cycle after accept
//   upd_valid/upd_addr/upd_taken/upd_ready resolved-branch update
//   init_done                              power-up sweep complete
//   bht_en/bht_we/bht_addr/bht_wdata       array port command
//   bht_rdata                              array read data (1 cycle latency)
// -----------------------------------------------------------------------------
interface bht_sched_if #(
    parameter int ADDR_W = 5
);
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_taken;
    logic              upd_ready;
    logic              init_done;
    logic              bht_en;
    logic              bht_we;
    logic [ADDR_W-1:0] bht_addr;
    logic [1:0]        bht_wdata;
    logic [1:0]        bht_rdata;

    modport slave (
        input  lookup_valid, lookup_addr, upd_valid, upd_addr, upd_taken, bht_rdata,
        output lookup_ready, pred_valid, pred_taken, upd_ready, init_done,
               bht_en, bht_we, bht_addr, bht_wdata
    );

    modport master (
        output lookup_valid, lookup_addr, upd_valid, upd_addr, upd_taken, bht_rdata,
        input  lookup_ready, pred_valid, pred_taken, upd_ready, init_done,
               bht_en, bht_we, bht_addr, bht_wdata
    );
endinterface

// File: rtl/bht_access_scheduler.sv
// -----------------------------------------------------------------------------
// bht_access_scheduler
// Owns the single port of a BHT of 2-bit saturating counters. After reset it
// sweeps every entry to INIT_STATE, then arbitrates each cycle between fetch
// lookups and queued resolution updates. Updates are buffered in a small FIFO
// and applied as a 2-cycle read-modify-write; after STARVE_MAX lookups have
// been granted over a waiting update, the update is forced through.
//
// Ports:
//   clk     in   clock, all state on rising edge
//   arst_n  in   asynchronous active-low reset
//   bus     slave modport of bht_sched_if (lookup, prediction, update,
//           init_done and array port signals)
//   stat_lookups/stat_updates/stat_stalls  out [15:0], only when the macro
//           BHT_SCHED_STATS_EN is defined: saturating event counters.
//
// Optional feature: define BHT_SCHED_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module bht_access_scheduler #(
    parameter int         ADDR_W     = 5,
    parameter int         DEPTH      = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter int         STARVE_MAX = 3,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        arst_n,
`ifdef BHT_SCHED_STATS_EN
    output logic [15:0] stat_lookups,
    output logic [15:0] stat_updates,
    output logic [15:0] stat_stalls,
`endif
    bht_sched_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_WR} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic              r_fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;
    logic              r_pred_valid;
    logic              r_pred_taken;
    logic              r_init_done;

    logic              w_empty;
    logic              w_full;
    logic              w_force;
    logic              w_lookup_acc;
    logic              w_upd_issue;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_head_taken;

    function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        else       return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // ---------------- arbitration ----------------
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_force      = !w_empty && (r_starve == STV_MAX);
    assign w_head_addr  = r_fifo_addr[r_rptr];
    assign w_head_taken = r_fifo_taken[r_rptr];

    assign bus.lookup_ready = (r_state == S_IDLE) && !w_force;
    assign w_lookup_acc     = bus.lookup_valid && bus.lookup_ready;
    // Lookups win unless an update is being forced; an idle port drains the FIFO.
    assign w_upd_issue      = (r_state == S_IDLE) && !w_empty && (w_force || !bus.lookup_valid);

    assign bus.upd_ready = !w_full;
    assign w_push        = bus.upd_valid && !w_full;
    assign w_pop         = (r_state == S_UPD_WR);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= S_INIT;
        else         r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_INIT:   if (r_idx == LAST_IDX) w_state_nxt = S_IDLE;
            S_IDLE:   if (w_upd_issue)       w_state_nxt = S_UPD_WR;
            S_UPD_WR:                        w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs (array port) ----------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.bht_en    = 1'b0;
        bus.bht_we    = 1'b0;
        bus.bht_addr  = '0;
        bus.bht_wdata = '0;
        unique case (r_state)
            S_INIT: begin
                bus.bht_en    = 1'b1;
                bus.bht_we    = 1'b1;
                bus.bht_addr  = r_idx;
                bus.bht_wdata = INIT_STATE;
            end
            S_IDLE: begin
                if (w_upd_issue) begin
                    bus.bht_en   = 1'b1;
                    bus.bht_addr = w_head_addr;
                end else if (w_lookup_acc) begin
                    bus.bht_en   = 1'b1;
                    bus.bht_addr = bus.lookup_addr;
                end
            end
            S_UPD_WR: begin
                // Head entry is still in the FIFO; it pops at the end of this cycle.
                bus.bht_en    = 1'b1;
                bus.bht_we    = 1'b1;
                bus.bht_addr  = w_head_addr;
                bus.bht_wdata = sat_next(bus.bht_rdata, w_head_taken);
            end
            default: ;
        endcase
    end

    // ---------------- sweep index and init flag ----------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_idx       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_init_done <= 1'b1;
        end
    end

    // ---------------- update FIFO ----------------
    // NOTE: the entry storage has no reset; validity is carried entirely by
    // the reset pointers/count, so resetting the array would only cost area.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr]  <= bus.upd_addr;
            r_fifo_taken[r_wptr] <= bus.upd_taken;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- anti-starvation counter ----------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            r_starve <= '0;
        else if (w_upd_issue || w_empty)
            r_starve <= '0;
        else if (w_lookup_acc && (r_starve != STV_MAX))
            r_starve <= r_starve + 1'b1;
    end

    // ---------------- prediction ----------------
    // pred_taken shows the array data directly in the response cycle and
    // holds the last prediction otherwise.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            r_pred_valid <= w_lookup_acc;
            if (r_pred_valid) r_pred_taken <= bus.bht_rdata[1];
        end
    end

    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_valid ? bus.bht_rdata[1] : r_pred_taken;
    assign bus.init_done  = r_init_done;

`ifdef BHT_SCHED_STATS_EN
    // ---------------- statistics ----------------
    logic [15:0] r_stat_lookups;
    logic [15:0] r_stat_updates;
    logic [15:0] r_stat_stalls;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stat_lookups <= '0;
            r_stat_updates <= '0;
            r_stat_stalls  <= '0;
        end else begin
            if (w_lookup_acc && (r_stat_lookups != 16'hFFFF))
                r_stat_lookups <= r_stat_lookups + 16'd1;
            if (w_pop && (r_stat_updates != 16'hFFFF))
                r_stat_updates <= r_stat_updates + 16'd1;
            if (bus.lookup_valid && !bus.lookup_ready && (r_stat_stalls != 16'hFFFF))
                r_stat_stalls <= r_stat_stalls + 16'd1;
        end
    end

    assign stat_lookups = r_stat_lookups;
    assign stat_updates = r_stat_updates;
    assign stat_stalls  = r_stat_stalls;
`endif

endmodule
